// File: rtl/pe_row_ctrl_if.sv
// Command/config and buffer-read/PE-control bundle between a host and one PE-row sequencer.
// The host drives "master"; the sequencer uses "slave".
interface pe_row_ctrl_if #(
    parameter int unsigned K_MAX      = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DIM_WIDTH  = 8
);
    localparam int unsigned K_W  = $clog2(K_MAX + 1);
    localparam int unsigned WA_W = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    logic                  start;
    logic                  abort;
    logic [K_W-1:0]        cfg_k;
    logic [DIM_WIDTH-1:0]  cfg_w;
    logic [DIM_WIDTH-1:0]  cfg_rows;
    logic [ADDR_WIDTH-1:0] cfg_ifm_base;

    logic                  wgt_rd_en;
    logic [WA_W-1:0]       wgt_addr;
    logic                  ifm_rd_en;
    logic [ADDR_WIDTH-1:0] ifm_addr;
    logic                  set_reg;
    logic                  psum_valid;
    logic                  row_last;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, abort, cfg_k, cfg_w, cfg_rows, cfg_ifm_base,
        input  wgt_rd_en, wgt_addr, ifm_rd_en, ifm_addr, set_reg,
               psum_valid, row_last, busy, done, err
    );

    modport slave (
        input  start, abort, cfg_k, cfg_w, cfg_rows, cfg_ifm_base,
        output wgt_rd_en, wgt_addr, ifm_rd_en, ifm_addr, set_reg,
               psum_valid, row_last, busy, done, err
    );
endinterface

// File: rtl/pe_row_ctrl.sv
// Row-stationary PE chain sequencer: loads K weights, then streams R ifm rows past the chain,
// flagging the cycles on which the chain tail holds a valid psum.
module pe_row_ctrl #(
    parameter int unsigned K_MAX      = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DIM_WIDTH  = 8,
    parameter int unsigned MEM_LAT    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    pe_row_ctrl_if.slave  bus
);
    localparam int unsigned K_W    = $clog2(K_MAX + 1);
    localparam int unsigned WA_W   = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int unsigned POS_W  = $clog2((1 << DIM_WIDTH) + MEM_LAT);
    localparam int unsigned LAT_M1 = MEM_LAT - 1;

    typedef enum logic [2:0] {IDLE, LOAD_WGT, STREAM, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [POS_W-1:0]      cnt_q, cnt_d;
    logic [DIM_WIDTH-1:0]  row_q, row_d;
    logic [ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [DIM_WIDTH-1:0]  w_q, w_d;
    logic [DIM_WIDTH-1:0]  rows_q, rows_d;
    logic                  bad_q, bad_d;

    logic                  wgt_rd_en_q, wgt_rd_en_d;
    logic [WA_W-1:0]       wgt_addr_q, wgt_addr_d;
    logic                  ifm_rd_en_q, ifm_rd_en_d;
    logic [ADDR_WIDTH-1:0] ifm_addr_q, ifm_addr_d;
    logic                  set_reg_q, set_reg_d;
    logic                  psum_valid_q, psum_valid_d;
    logic                  row_last_q, row_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  cfg_bad;
    logic                  in_row;
    logic [POS_W-1:0]      last_wgt, last_col, last_pos, first_psum;

    assign cfg_bad = (bus.cfg_k == '0) || (32'(bus.cfg_k) > K_MAX) ||
                     (32'(bus.cfg_k) > 32'(bus.cfg_w)) || (bus.cfg_rows == '0);

    // cnt runs 0..W+MEM_LAT-1 across a row's STREAM and DRAIN phases
    assign last_wgt   = POS_W'(k_q) - POS_W'(1);
    assign last_col   = POS_W'(w_q) - POS_W'(1);
    assign last_pos   = POS_W'(w_q) + POS_W'(LAT_M1);
    assign first_psum = POS_W'(k_q) + POS_W'(LAT_M1);

    always_ff @(posedge clk) begin
        if (rst_n) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        row_addr_d = row_addr_q;
        k_d        = k_q;
        w_d        = w_q;
        rows_d     = rows_q;
        bad_d      = bad_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    k_d        = bus.cfg_k;
                    w_d        = bus.cfg_w;
                    rows_d     = bus.cfg_rows;
                    row_addr_d = bus.cfg_ifm_base;
                    row_d      = '0;
                    cnt_d      = '0;
                    bad_d      = cfg_bad;
                    state_d    = cfg_bad ? DONE : LOAD_WGT;
                end
            end
            LOAD_WGT: begin
                if (cnt_q == last_wgt) begin
                    cnt_d   = '0;
                    state_d = STREAM;
                end else begin
                    cnt_d = cnt_q + POS_W'(1);
                end
            end
            STREAM: begin
                cnt_d = cnt_q + POS_W'(1);
                if (cnt_q == last_col) state_d = DRAIN;
            end
            DRAIN: begin
                if (cnt_q == last_pos) begin
                    if (row_q == rows_q - DIM_WIDTH'(1)) begin
                        state_d = DONE;
                    end else begin
                        row_d      = row_q + DIM_WIDTH'(1);
                        row_addr_d = row_addr_q + ADDR_WIDTH'(w_q);
                        cnt_d      = '0;
                        state_d    = STREAM;
                    end
                end else begin
                    cnt_d = cnt_q + POS_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.abort && (state_q != IDLE)) state_d = IDLE;

        // Outputs are decoded from the state being entered and registered alongside it
        in_row       = (state_d == STREAM) || (state_d == DRAIN);
        wgt_rd_en_d  = (state_d == LOAD_WGT);
        wgt_addr_d   = wgt_rd_en_d ? WA_W'(cnt_d) : '0;
        ifm_rd_en_d  = (state_d == STREAM);
        ifm_addr_d   = ifm_rd_en_d ? (row_addr_d + ADDR_WIDTH'(cnt_d)) : '0;
        set_reg_d    = in_row;
        psum_valid_d = in_row && (cnt_d >= first_psum);
        row_last_d   = in_row && (cnt_d == last_pos);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
        err_d        = done_d && bad_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q        <= '0;
            row_q        <= '0;
            row_addr_q   <= '0;
            k_q          <= '0;
            w_q          <= '0;
            rows_q       <= '0;
            bad_q        <= 1'b0;
            wgt_rd_en_q  <= 1'b0;
            wgt_addr_q   <= '0;
            ifm_rd_en_q  <= 1'b0;
            ifm_addr_q   <= '0;
            set_reg_q    <= 1'b0;
            psum_valid_q <= 1'b0;
            row_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            row_addr_q   <= row_addr_d;
            k_q          <= k_d;
            w_q          <= w_d;
            rows_q       <= rows_d;
            bad_q        <= bad_d;
            wgt_rd_en_q  <= wgt_rd_en_d;
            wgt_addr_q   <= wgt_addr_d;
            ifm_rd_en_q  <= ifm_rd_en_d;
            ifm_addr_q   <= ifm_addr_d;
            set_reg_q    <= set_reg_d;
            psum_valid_q <= psum_valid_d;
            row_last_q   <= row_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.wgt_rd_en  = wgt_rd_en_q;
    assign bus.wgt_addr   = wgt_addr_q;
    assign bus.ifm_rd_en  = ifm_rd_en_q;
    assign bus.ifm_addr   = ifm_addr_q;
    assign bus.set_reg    = set_reg_q;
    assign bus.psum_valid = psum_valid_q;
    assign bus.row_last   = row_last_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_pe_row_ctrl.sv
// Bench for pe_row_ctrl: directed jobs plus randomized jobs/aborts/resets, each cycle compared
// against a per-cycle timeline computed from the job parameters.
module tb_pe_row_ctrl;
    localparam int unsigned K_MAX      = 8;
    localparam int unsigned ADDR_WIDTH = 10;
    localparam int unsigned DIM_WIDTH  = 8;
    localparam int unsigned MEM_LAT    = 1;
    localparam int unsigned K_W        = $clog2(K_MAX + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pe_row_ctrl_if #(.K_MAX(K_MAX), .ADDR_WIDTH(ADDR_WIDTH), .DIM_WIDTH(DIM_WIDTH)) bus ();

    pe_row_ctrl #(
        .K_MAX(K_MAX), .ADDR_WIDTH(ADDR_WIDTH), .DIM_WIDTH(DIM_WIDTH), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bundle: {pad, wgt_rd_en, wgt_addr[2:0], ifm_rd_en, ifm_addr[9:0], set_reg, psum_valid, row_last, busy, done, err}
    function automatic logic [31:0] observe();
        return {11'b0, bus.wgt_rd_en, 3'(bus.wgt_addr), bus.ifm_rd_en, 10'(bus.ifm_addr),
                bus.set_reg, bus.psum_valid, bus.row_last, bus.busy, bus.done, bus.err};
    endfunction

    function automatic bit is_bad(input int k, input int w, input int r);
        return (k == 0) || (k > int'(K_MAX)) || (k > w) || (r == 0);
    endfunction

    function automatic int done_cycle(input int k, input int w, input int r);
        if (is_bad(k, w, r)) return 1;
        return k + 1 + r * (w + int'(MEM_LAT));
    endfunction

    // Expected outputs in cycle t of a job whose start was sampled at the end of cycle 0
    function automatic logic [31:0] expect_at(input int t, input int k, input int w, input int r,
                                              input int base, input int kill);
        bit we = 0, ie = 0, sr = 0, pv = 0, rl = 0, by = 0, dn = 0, er = 0;
        int wa = 0, ia = 0, dc, s, lat;
        lat = int'(MEM_LAT);
        if (kill > 0 && t > kill) return 32'h0;
        dc = done_cycle(k, w, r);
        if (t >= 1 && t <= dc) by = 1;
        if (t == dc) dn = 1;
        if (is_bad(k, w, r)) begin
            er = (t == dc);
        end else begin
            if (t >= 1 && t <= k) begin
                we = 1;
                wa = t - 1;
            end
            for (int row = 0; row < r; row++) begin
                s = k + 1 + row * (w + lat);
                if (t >= s && t <= s + w - 1) begin
                    ie = 1;
                    sr = 1;
                    ia = (base + row * w + (t - s)) % (1 << ADDR_WIDTH);
                end
                if (t >= s + w && t <= s + w + lat - 1) sr = 1;
                if (t >= s + k + lat - 1 && t <= s + w + lat - 1) pv = 1;
                if (t == s + w + lat - 1) rl = 1;
            end
        end
        return {11'b0, we, 3'(wa), ie, 10'(ia), sr, pv, rl, by, dn, er};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input int k, input int w, input int r, input int base);
        bus.cfg_k        = K_W'(k);
        bus.cfg_w        = DIM_WIDTH'(w);
        bus.cfg_rows     = DIM_WIDTH'(r);
        bus.cfg_ifm_base = ADDR_WIDTH'(base);
    endtask

    // Starts a job in the current (idle) cycle; returns in the first idle cycle after it ends.
    // kill>0 aborts (or resets if kill_rst) during that cycle; noise scrambles cfg and pokes start mid-job.
    task automatic run_job(input int k, input int w, input int r, input int base,
                           input int kill, input bit kill_rst, input bit noise, input string name);
        int dc, last;
        drive_cfg(k, w, r, base);
        bus.start = 1'b1;
        bus.abort = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        dc   = done_cycle(k, w, r);
        last = (kill > 0) ? kill + 1 : dc + 1;
        for (int t = 1; t <= last; t++) begin
            step();
            check_eq($sformatf("%s t%0d", name, t), observe(), expect_at(t, k, w, r, base, kill));
            bus.start = 1'b0;
            bus.abort = 1'b0;
            rst_n     = 1'b0;
            if (noise && t < last) begin
                drive_cfg($urandom_range(0, 15), $urandom_range(0, 255),
                          $urandom_range(0, 255), $urandom_range(0, 1023));
                bus.start = 1'($urandom_range(0, 1));
            end
            if (t == kill) begin
                if (kill_rst) rst_n = 1'b1;
                else          bus.abort = 1'b1;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst_n     = 1'b0;
    endtask

    // Idle cycles with abort toggling; outputs must stay quiet
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.abort = 1'($urandom_range(0, 1));
            step();
            check_eq($sformatf("idle%0d", i), observe(), 32'h0);
        end
        bus.abort = 1'b0;
    endtask

    initial begin
        int k, w, r, base, kill;
        bit krst;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        drive_cfg(0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        step();
        check_eq("reset", observe(), 32'h0);
        rst_n = 1'b0;

        run_job(3, 8, 1, 0,    0, 0, 0, "tp_basic");
        run_job(3, 8, 2, 100,  0, 0, 0, "tp_two_rows");
        run_job(4, 3, 1, 0,    0, 0, 0, "err_k_gt_w");
        run_job(0, 8, 1, 0,    0, 0, 0, "err_k0");
        run_job(3, 8, 0, 0,    0, 0, 0, "err_r0");
        run_job(9, 12, 1, 0,   0, 0, 0, "err_k_gt_kmax");
        run_job(3, 8, 1, 0,    9, 0, 0, "abort_c9");
        run_job(3, 8, 1, 0,    0, 0, 0, "after_abort");
        run_job(3, 8, 2, 5,    6, 1, 1, "rst_stream");
        run_job(3, 8, 2, 100,  0, 0, 1, "cfg_noise");
        run_job(8, 8, 1, 0,    0, 0, 0, "k8_w8");
        run_job(2, 10, 2, 1020, 0, 0, 0, "addr_wrap");
        idle(4);

        for (int j = 0; j < 60; j++) begin
            k    = $urandom_range(0, 9);
            w    = $urandom_range(1, 20);
            r    = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            base = $urandom_range(0, 1023);
            kill = 0;
            krst = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                kill = $urandom_range(1, done_cycle(k, w, r));
                krst = 1'($urandom_range(0, 1));
            end
            run_job(k, w, r, base, kill, krst, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", j));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pe_row_ctrl.md
# pe_row_ctrl

Sequencer for one row-stationary PE chain of up to K_MAX PEs. On `start` it loads the filter row into the PEs' weight registers, then streams one or more input-feature-map rows past them. It drives the shared `set_reg` enable of the PE psum registers and flags the cycles on which the chain's tail `psum_out` holds a valid convolution output. It sits between the global-buffer read ports and the PE chain, one instance per PE row.

## Interface
- `K_MAX`, 8: largest supported filter width (PEs in chain)
- `ADDR_WIDTH`, 10: ifm / weight buffer address width
- `DIM_WIDTH`, 8: width of row-length and row-count config fields
- `MEM_LAT`, 1: buffer read latency in cycles (≥1)

- `clk` in 1: clock, all logic on rising edge
- `rst_n` in 1: reset, synchronous, active-high (asserted = 1)
- `start` in 1: begin job; sampled only in IDLE
- `abort` in 1: cancel job; IDLE next cycle, no `done`
- `cfg_k` in $clog2(K_MAX+1): filter width K
- `cfg_w` in DIM_WIDTH: ifm row length W
- `cfg_rows` in DIM_WIDTH: ifm rows R to process with the same weights
- `cfg_ifm_base` in ADDR_WIDTH: ifm start address
- `wgt_rd_en` out 1: weight buffer read strobe
- `wgt_addr` out $clog2(K_MAX): weight index, equals target PE index
- `ifm_rd_en` out 1: ifm buffer read strobe
- `ifm_addr` out ADDR_WIDTH: ifm read address
- `set_reg` out 1: psum register enable to all PEs
- `psum_valid` out 1: chain tail output valid this cycle
- `row_last` out 1: with `psum_valid`, last output of the current row
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle completion pulse
- `err` out 1: config error, valid with `done`

## Operation
- Config is latched on the accepted `start`. Later changes to `cfg_*` have no effect until the next job.
- States: IDLE, LOAD_WGT, STREAM, DRAIN, DONE.
- IDLE → LOAD_WGT on `start`. If K=0, K>K_MAX, K>W or R=0, go IDLE → DONE with `err`=1 and issue no reads.
- LOAD_WGT: K cycles. `wgt_rd_en`=1 and `wgt_addr` = 0..K-1. Then → STREAM.
- STREAM: W cycles per row. `ifm_rd_en`=1 and `ifm_addr` = base + r·W + c, where c = 0..W-1 and r = row index. Then → DRAIN.
- DRAIN: MEM_LAT cycles. No reads. Then, if r < R-1, increment r and → STREAM; otherwise → DONE.
- DONE: 1 cycle, `done`=1. Then → IDLE.
- `set_reg`=1 in STREAM and DRAIN, 0 otherwise (PE psums hold).
- `psum_valid`: W-K+1 pulses per row, on contiguous cycles. The first comes K+MEM_LAT-1 cycles after the row's first STREAM cycle; the last is on the row's final DRAIN cycle. `row_last` coincides with that last pulse.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. No error is raised on wrap.
- `abort` (any non-IDLE state) → IDLE next cycle. All strobes drop; `done` and `err` stay 0. `abort` in IDLE is ignored. If `abort` and `start` are both high in IDLE, `start` wins.
- `start` while busy is ignored.

## Timing
- Reset: state IDLE, all counters 0. Every output is 0 (`wgt_addr` 0, `ifm_addr` 0). This holds from the cycle after `rst_n` is sampled high, in any state, mid-job included.
- All outputs are registered, decoded from the current state.
- Cycle numbering: `start` sampled high at the edge ending cycle 0.
  - LOAD_WGT occupies cycles 1..K.
  - Row r STREAM begins at cycle s_r, where s_0 = K+1 and s_{r+1} = s_r + W + MEM_LAT.
  - DONE is at cycle s_0 + R·(W+MEM_LAT). `busy` is low the next cycle.
- A new `start` can be accepted on the first IDLE cycle after DONE.

## Test plan
- K=3, W=8, R=1, MEM_LAT=1, base=0, `start` in cycle 0 → `wgt_rd_en` in cycles 1..3 with addr 0,1,2. `ifm_rd_en` in cycles 4..11 with addr 0..7. `psum_valid` in cycles 7..12, 6 pulses, `row_last` in cycle 12. `done` in cycle 13. `busy` low in cycle 14.
- Same config with R=2, base=100 → row 1 `ifm_addr` 108..115 in cycles 13..20. `psum_valid` in 16..21. `done` in cycle 22.
- K=4, W=3 → `done`=`err`=1 in cycle 1 and no read strobes. Repeat with K=0 and with R=0 for the same result.
- `abort` in cycle 9 of the first test → all outputs 0 from cycle 10, no `done`. A new `start` is accepted at cycle 10.
- `rst_n`=1 in STREAM → all outputs 0 and state IDLE next cycle. `start` in mid-job and `cfg_*` changes mid-job → ignored, addresses unaffected.
- K=8, W=8 → exactly 1 `psum_valid` with `row_last`, on the final DRAIN cycle.
